// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for DIV/DIVU in the EX stage.
// Radix-2 restoring division, one quotient bit per cycle. The pipeline is
// stalled while the divider is busy. Quotient (LO) and remainder (HI) are
// then presented for one cycle on the HI/LO write path.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             sign_q;
  logic             sign_r;

  logic             start_ok;
  logic [WIDTH-1:0] opa_mag;
  logic [WIDTH-1:0] opb_mag;
  logic [WIDTH:0]   shifted;
  logic             trial_ge;
  logic [WIDTH-1:0] trial_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_step;

  assign start_ok  = div_start & ~annul;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Operand magnitudes and the trial subtraction for one restoring step
  always_comb begin
    opa_mag    = opa;
    opb_mag    = opb;
    if (div_signed && opa[WIDTH-1]) opa_mag = '0 - opa;
    if (div_signed && opb[WIDTH-1]) opb_mag = '0 - opb;
    shifted    = {rem_q, quo_q[WIDTH-1]};
    trial_ge   = (shifted >= {1'b0, dvsr_q});
    trial_diff = shifted[WIDTH-1:0] - dvsr_q;
    rem_next   = trial_ge ? trial_diff : shifted[WIDTH-1:0];
    quo_next   = {quo_q[WIDTH-2:0], trial_ge};
  end

  // Pipeline stall: held while a request is being accepted or the divider is iterating
  always_comb begin
    div_stall = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    div_stall = start_ok;
        BUSY:    div_stall = 1'b1;
        default: div_stall = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with datapath registers and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      lo_out       <= '0;
      hi_out       <= '0;
      div_zero     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start_ok) begin
            if (opb == '0) begin
              lo_out       <= '1;
              hi_out       <= opa;
              div_zero     <= 1'b1;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              rem_q  <= '0;
              quo_q  <= opa_mag;
              dvsr_q <= opb_mag;
              sign_q <= div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
              sign_r <= div_signed & opa[WIDTH-1];
              cnt    <= '0;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (annul) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + 1'b1;
            if (last_step) begin
              lo_out       <= sign_q ? ('0 - quo_next) : quo_next;
              hi_out       <= sign_r ? ('0 - rem_next) : rem_next;
              div_zero     <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed self-checking bench for div_seq_ctrl.
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        div_start;
  logic        div_signed;
  logic        annul;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] lo_out;
  logic [31:0] hi_out;
  logic        div_zero;

  int checks;
  int failures;

  div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .annul        (annul),
    .opa          (opa),
    .opb          (opb),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .lo_out       (lo_out),
    .hi_out       (hi_out),
    .div_zero     (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and follow it until result_valid or a cycle budget runs out.
  // Cycle 0 is the cycle in which the request is first presented.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int drop_k, input bit keep_start,
                        output int stalls, output int vcycle,
                        output logic [31:0] lo, output logic [31:0] hi, output logic dz);
    int k;
    @(negedge clk);
    opa = a; opb = b; div_signed = s; div_start = 1'b1; annul = 1'b0;
    stalls = 0; vcycle = -1; k = 0;
    lo = 'x; hi = 'x; dz = 1'bx;
    forever begin
      #1;
      if (div_stall === 1'b1) stalls++;
      if (result_valid === 1'b1) begin
        vcycle = k; lo = lo_out; hi = hi_out; dz = div_zero;
        break;
      end
      if (k == drop_k) div_start = 1'b0;
      if (k >= 200) break;
      @(negedge clk);
      k++;
    end
    if (!keep_start) div_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; div_start = 1'b1; div_signed = 1'b0; annul = 1'b0;
    opa = 32'd5; opb = 32'd1;
    #2;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", div_stall); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", result_valid); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi_out); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dz: got %b expected 0", div_zero); end
    @(negedge clk); @(negedge clk);
    div_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("[TB] FAIL idle_stall: got %b expected 0", div_stall); end
  endtask

  task automatic test_divide();
    logic [31:0] va[5]  = '{32'd100, 32'hFFFFFF9C, 32'd100,    32'hFFFFFF9C, 32'hFFFFFFFF};
    logic [31:0] vb[5]  = '{32'd7,   32'd7,        32'hFFFFFFF9, 32'd7,      32'd2};
    logic        vs[5]  = '{1'b0,    1'b1,         1'b1,       1'b0,         1'b0};
    logic [31:0] elo[5] = '{32'd14,  32'hFFFFFFF2, 32'hFFFFFFF2, 32'h24924916, 32'h7FFFFFFF};
    logic [31:0] ehi[5] = '{32'd2,   32'hFFFFFFFE, 32'd2,      32'd2,        32'd1};
    int stalls, vcycle;
    logic [31:0] lo, hi;
    logic dz;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], -1, 1'b0, stalls, vcycle, lo, hi, dz);
      checks++; if (vcycle !== 33) begin failures++; $display("[TB] FAIL div%0d_latency: got %0d expected 33", i, vcycle); end
      checks++; if (stalls !== 33) begin failures++; $display("[TB] FAIL div%0d_stalls: got %0d expected 33", i, stalls); end
      checks++; if (lo !== elo[i]) begin failures++; $display("[TB] FAIL div%0d_lo: got %h expected %h", i, lo, elo[i]); end
      checks++; if (hi !== ehi[i]) begin failures++; $display("[TB] FAIL div%0d_hi: got %h expected %h", i, hi, ehi[i]); end
      checks++; if (dz !== 1'b0) begin failures++; $display("[TB] FAIL div%0d_dz: got %b expected 0", i, dz); end
      @(negedge clk); #1;
      checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL div%0d_valid_pulse: got %b expected 0", i, result_valid); end
    end
  endtask

  task automatic test_div_zero();
    int stalls, vcycle;
    logic [31:0] lo, hi;
    logic dz;
    run_op(32'h1234, 32'h0, 1'b0, -1, 1'b0, stalls, vcycle, lo, hi, dz);
    checks++; if (vcycle !== 1) begin failures++; $display("[TB] FAIL dz_latency: got %0d expected 1", vcycle); end
    checks++; if (stalls !== 1) begin failures++; $display("[TB] FAIL dz_stalls: got %0d expected 1", stalls); end
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL dz_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h1234) begin failures++; $display("[TB] FAIL dz_hi: got %h expected 00001234", hi); end
    checks++; if (dz !== 1'b1) begin failures++; $display("[TB] FAIL dz_flag: got %b expected 1", dz); end
    @(negedge clk); #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL dz_valid_pulse: got %b expected 0", result_valid); end
  endtask

  task automatic test_overflow();
    int stalls, vcycle;
    logic [31:0] lo, hi;
    logic dz;
    // div_start is dropped mid-operation; the division must still complete
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 3, 1'b0, stalls, vcycle, lo, hi, dz);
    checks++; if (vcycle !== 33) begin failures++; $display("[TB] FAIL ovf_latency: got %0d expected 33", vcycle); end
    checks++; if (lo !== 32'h80000000) begin failures++; $display("[TB] FAIL ovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("[TB] FAIL ovf_hi: got %h expected 00000000", hi); end
    checks++; if (dz !== 1'b0) begin failures++; $display("[TB] FAIL ovf_dz: got %b expected 0", dz); end
  endtask

  task automatic test_annul();
    int seen;
    // Annul while idle suppresses the start
    @(negedge clk);
    opa = 32'd15; opb = 32'd4; div_signed = 1'b0; div_start = 1'b1; annul = 1'b1;
    #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("[TB] FAIL annul_idle_stall: got %b expected 0", div_stall); end
    @(negedge clk);
    div_start = 1'b0; annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      #1; if (result_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL annul_idle_valid: got %0d pulses expected 0", seen); end
    // Annul in BUSY cycle 10 returns to idle without a result
    opa = 32'd15; opb = 32'd4; div_start = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge clk);
    #1;
    checks++; if (div_stall !== 1'b1) begin failures++; $display("[TB] FAIL annul_busy_stall: got %b expected 1", div_stall); end
    annul = 1'b1; div_start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("[TB] FAIL annul_after_stall: got %b expected 0", div_stall); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      #1; if (result_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL annul_busy_valid: got %0d pulses expected 0", seen); end
    checks++; if (lo_out !== 32'h80000000) begin failures++; $display("[TB] FAIL annul_lo_kept: got %h expected 80000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("[TB] FAIL annul_hi_kept: got %h expected 00000000", hi_out); end
  endtask

  task automatic test_back_to_back();
    int stalls, vcycle;
    logic [31:0] lo, hi;
    logic dz;
    run_op(32'd15, 32'd4, 1'b0, -1, 1'b1, stalls, vcycle, lo, hi, dz);
    checks++; if (vcycle !== 33) begin failures++; $display("[TB] FAIL b2b_first_latency: got %0d expected 33", vcycle); end
    checks++; if (lo !== 32'd3) begin failures++; $display("[TB] FAIL b2b_first_lo: got %h expected 00000003", lo); end
    checks++; if (hi !== 32'd3) begin failures++; $display("[TB] FAIL b2b_first_hi: got %h expected 00000003", hi); end
    // div_start stays high; the second request begins the cycle after DONE
    run_op(32'd9, 32'd3, 1'b0, -1, 1'b1, stalls, vcycle, lo, hi, dz);
    checks++; if (vcycle !== 33) begin failures++; $display("[TB] FAIL b2b_second_spacing: got %0d expected 33 (34 from first pulse)", vcycle); end
    checks++; if (stalls !== 33) begin failures++; $display("[TB] FAIL b2b_second_stalls: got %0d expected 33", stalls); end
    checks++; if (lo !== 32'd3) begin failures++; $display("[TB] FAIL b2b_second_lo: got %h expected 00000003", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL b2b_second_hi: got %h expected 00000000", hi); end
    div_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    opa = 32'd15; opb = 32'd4; div_signed = 1'b0; div_start = 1'b1; annul = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    #1;
    checks++; if (div_stall !== 1'b1) begin failures++; $display("[TB] FAIL rmid_busy_stall: got %b expected 1", div_stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("[TB] FAIL rmid_stall: got %b expected 0", div_stall); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("[TB] FAIL rmid_lo: got %h expected 00000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin failures++; $display("[TB] FAIL rmid_hi: got %h expected 00000000", hi_out); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_valid: got %b expected 0", result_valid); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL rmid_dz: got %b expected 0", div_zero); end
    @(negedge clk);
    div_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("[TB] FAIL rmid_after_stall: got %b expected 0", div_stall); end
  endtask

  // Run every scenario in order, then report
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_divide();
    test_div_zero();
    test_overflow();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU datapath in the EX stage of the MIPS core.
- Triggered by the decoder's `div` and `hassign` controls. Performs radix-2 restoring division, one quotient bit per cycle.
- Stalls the pipeline while busy, then presents quotient (LO) and remainder (HI) for one cycle, to be written through the HI/LO write path (`hilo_en` = 11).
- Flush input cancels an in-flight division.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
div_start  in  1  EX holds a DIV/DIVU (decoder `div`); level, held while stalled.
div_signed  in  1  1 = DIV (signed), 0 = DIVU; decoder `hassign`.
annul  in  1  EX flush; cancels pending/in-flight division.
opa  in  WIDTH  dividend (rs).
opb  in  WIDTH  divisor (rt).
div_stall  out  1  freeze PC/IF/ID/EX; combinational.
result_valid  out  1  HI/LO results valid this cycle; pipeline writes HI/LO.
lo_out  out  WIDTH  quotient, registered.
hi_out  out  WIDTH  remainder, registered.
div_zero  out  1  divisor was zero for the current result, registered.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, internal regs=0, lo_out=hi_out=0, div_zero=0, result_valid=0. div_stall=0 while in reset.
- States:
  - IDLE: waiting for a request.
  - BUSY: one restoring step per cycle.
  - DONE: results presented for one cycle.
- IDLE:
  - div_stall = div_start & ~annul.
  - On edge with div_start & ~annul & opb != 0:
    - Latch |opa| and |opb|. Magnitudes are taken only if div_signed; else raw values are used.
    - Latch sign_q = div_signed & (opa[MSB] ^ opb[MSB]) and sign_r = div_signed & opa[MSB].
    - Clear partial remainder; counter=0; go to BUSY.
  - On edge with div_start & ~annul & opb == 0: go to DONE with lo_out = all-ones, hi_out = opa, div_zero = 1 (2-cycle op).
- BUSY:
  - div_stall = 1.
  - Each edge:
    - Shift {rem, quo} left 1, bringing in the dividend MSB.
    - Trial subtract rem - divisor (WIDTH+1 bits). If non-negative, keep the difference and set quo LSB = 1.
    - counter += 1.
  - After the WIDTH-th step (counter == WIDTH-1 at the edge), go to DONE:
    - lo_out = sign_q ? -quo : quo.
    - hi_out = sign_r ? -rem : rem.
    - div_zero = 0.
  - Arithmetic wraps modulo 2^WIDTH; 0x80000000 / 0xFFFFFFFF signed yields lo=0x80000000, hi=0.
- DONE:
  - result_valid = 1, div_stall = 0; the pipeline advances and consumes lo_out/hi_out this cycle.
  - Next edge returns to IDLE unconditionally. div_start still high here belongs to the same instruction and must not restart.
- Latency (nonzero divisor): start cycle + WIDTH BUSY cycles are stalled (33 total for WIDTH=32); result_valid in cycle 33 relative to the start cycle. Back-to-back DIVs: the second starts the cycle after DONE.
- annul: in IDLE suppresses the start. In BUSY, the next edge goes to IDLE with no result_valid; lo_out/hi_out keep their previous values. annul during DONE does not suppress result_valid; the pipeline must gate the write.
- rst_n asserted mid-operation: immediate return to reset values.
- div_start low while in BUSY is ignored; the operation completes.

Test Plan:
- DIVU 100/7: opa=100, opb=7, div_signed=0 → div_stall high 33 cycles; result_valid 1 cycle; lo_out=14, hi_out=2, div_zero=0.
- DIV -100/7: opa=0xFFFFFF9C, opb=7, div_signed=1 → lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2).
- Signed overflow: opa=0x80000000, opb=0xFFFFFFFF, div_signed=1 → lo_out=0x80000000, hi_out=0.
- Divide by zero: opa=0x1234, opb=0 → result_valid the cycle after start; lo_out=0xFFFFFFFF, hi_out=0x1234, div_zero=1; stall 1 cycle.
- Annul at BUSY cycle 10 → state IDLE next cycle; result_valid never asserted; prior lo_out/hi_out unchanged.
- Back-to-back DIVU 15/4 then 9/3 with div_start held → two result_valid pulses 34 cycles apart: (lo=3, hi=3), then (lo=3, hi=0). Then assert rst_n=0 mid-BUSY → all outputs 0 immediately.
